// File: rtl/clk_step_gen.sv
// clk_step_gen: board clock-enable generator with rate select,
// debounced step button, button/switch debouncers and a CE counter.
//
// Purpose
//   Produces a one-cycle CE on the board clock at a selected rate,
//   held high every cycle (SEL=B), or one CE per debounced press of
//   the step button (SEL=C..F). No derived or gated clocks.
// Ports
//   CLK, RESET      board clock, async active-low reset
//   SEL             rate select (synchronous to CLK)
//   BTN, SW         raw asynchronous buttons and switches
//   CNT_CLR         synchronous clear of TICK_CNT
//   CE              one-cycle clock-enable pulse
//   TICK_CNT        CE pulses since reset or clear
//   SEL_CUR         rate select in effect
//   BTN_DB/SW_DB    debounced levels
//   BTN_RISE        one-cycle pulse per debounced button press
// Build option
//   CLK_STEP_BURST_EN: a step button held for CLK_HZ cycles after
//   its press repeats CE every CLK_HZ/10 cycles until release.
module clk_step_gen #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned NBTN     = 5,
  parameter int unsigned NSW      = 16,
  parameter int unsigned STEP_IDX = 0,
  parameter int unsigned DEB_DIV  = 1_000_000,
  parameter int unsigned DEB_N    = 3
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [3:0]      SEL,
  input  logic [NBTN-1:0] BTN,
  input  logic [NSW-1:0]  SW,
  input  logic            CNT_CLR,
  output logic            CE,
  output logic [31:0]     TICK_CNT,
  output logic [3:0]      SEL_CUR,
  output logic [NBTN-1:0] BTN_DB,
  output logic [NBTN-1:0] BTN_RISE,
  output logic [NSW-1:0]  SW_DB
);

  localparam int unsigned NIN = NBTN + NSW;
  localparam int unsigned PW =
    (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int unsigned CW = $clog2(DEB_N + 1);
  localparam logic [PW-1:0] PRE_TOP = PW'(DEB_DIV - 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEB_N - 1);

  function automatic logic [31:0] div_of(
    input logic [3:0] s
  );
    logic [31:0] rate;
    logic [31:0] q;
    case (s)
      4'h0:    rate = 32'd1;
      4'h1:    rate = 32'd10;
      4'h2:    rate = 32'd100;
      4'h3:    rate = 32'd1_000;
      4'h4:    rate = 32'd10_000;
      4'h5:    rate = 32'd100_000;
      4'h6:    rate = 32'd1_000_000;
      4'h7:    rate = 32'd10_000_000;
      4'h8:    rate = 32'd20_000_000;
      4'h9:    rate = 32'd25_000_000;
      4'hA:    rate = 32'd50_000_000;
      default: rate = 32'd1;
    endcase
    q = CLK_HZ / rate;
    div_of = (q == 32'd0) ? 32'd1 : q;
  endfunction

  // ---------------- debounce ----------------
  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] db;
  logic [PW-1:0]  pre;
  logic           strobe;

  assign raw    = {SW, BTN};
  assign strobe = (pre == PRE_TOP);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      pre   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pre   <= strobe ? '0 : pre + 1'b1;
    end
  end

  for (genvar i = 0; i < NIN; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          lvl;

    assign db[i] = lvl;

    // Only strobes that disagree with the current level
    // advance the count; one agreeing strobe starts over.
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (strobe) begin
        if (sync2[i] != lvl) begin
          if (cnt == CNT_TOP) begin
            lvl <= ~lvl;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

  assign BTN_DB = db[NBTN-1:0];
  assign SW_DB  = db[NIN-1:NBTN];

  logic [NBTN-1:0] db_q;
  logic            step_rise;

  assign step_rise = BTN_DB[STEP_IDX] & ~db_q[STEP_IDX];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      db_q     <= '0;
      BTN_RISE <= '0;
    end else begin
      db_q     <= BTN_DB;
      BTN_RISE <= BTN_DB & ~db_q;
    end
  end

  // ---------------- rate / step select ----------------
  logic [31:0] div_cnt;
  logic        sel_chg;
  logic        step_mode;
  logic        hold_mode;
  logic        rpt_hit;
  logic        ce_nxt;

  assign sel_chg   = (SEL != SEL_CUR);
  assign step_mode = SEL_CUR[3] & SEL_CUR[2];
  assign hold_mode = (SEL_CUR == 4'hB);

`ifdef CLK_STEP_BURST_EN
  localparam int unsigned HOLD =
    (CLK_HZ == 0) ? 1 : CLK_HZ;
  localparam int unsigned REP =
    (CLK_HZ / 10 == 0) ? 1 : CLK_HZ / 10;

  logic        rpt_on;
  logic [31:0] rpt_cnt;

  // Gated by the live level so a release never lets a
  // final repeat slip out.
  assign rpt_hit = rpt_on & BTN_DB[STEP_IDX]
                 & (rpt_cnt == 32'd0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rpt_on  <= 1'b0;
      rpt_cnt <= '0;
    end else if (!step_mode || sel_chg
                 || !BTN_DB[STEP_IDX]) begin
      rpt_on  <= 1'b0;
      rpt_cnt <= '0;
    end else if (step_rise) begin
      rpt_on  <= 1'b1;
      rpt_cnt <= 32'(HOLD - 1);
    end else if (rpt_on) begin
      rpt_cnt <= (rpt_cnt == 32'd0)
               ? 32'(REP - 1) : rpt_cnt - 32'd1;
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  // A select change always swallows the CE of that cycle so
  // the new rate starts clean.
  always_comb begin
    ce_nxt = 1'b0;
    if (sel_chg)        ce_nxt = 1'b0;
    else if (step_mode) ce_nxt = step_rise | rpt_hit;
    else if (hold_mode) ce_nxt = 1'b1;
    else                ce_nxt = (div_cnt == 32'd0);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      SEL_CUR  <= '0;
      div_cnt  <= '0;
      CE       <= 1'b0;
      TICK_CNT <= '0;
    end else begin
      CE <= ce_nxt;
      if (sel_chg) begin
        SEL_CUR <= SEL;
        div_cnt <= div_of(SEL) - 32'd1;
      end else if (!step_mode && !hold_mode) begin
        div_cnt <= (div_cnt == 32'd0)
                 ? div_of(SEL_CUR) - 32'd1
                 : div_cnt - 32'd1;
      end
      if (CNT_CLR)     TICK_CNT <= '0;
      else if (ce_nxt) TICK_CNT <= TICK_CNT + 32'd1;
    end
  end

endmodule
